// File: rtl/addr_load_seq_pkg.sv
// Shared encodings for the address-register load sequencer: enable codes,
// operand modes and FSM state encoding.
package addr_load_seq_pkg;

  localparam logic [1:0] EN_HOLD = 2'b00;
  localparam logic [1:0] EN_LDNA = 2'b01;
  localparam logic [1:0] EN_LDB  = 2'b10;
  localparam logic [1:0] EN_SHL  = 2'b11;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_LONG   = 2'b01,
    MODE_SHORT  = 2'b10,
    MODE_RSV    = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LDNA   = 3'd1,
    S_CLR    = 3'd2,
    S_WAIT_B = 3'd3,
    S_LOAD_B = 3'd4,
    S_SHIFT  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // Enable code seen by the address register in each state.
  function automatic logic [1:0] en_decode(input state_t s);
    case (s)
      S_LDNA, S_CLR: return EN_LDNA;
      S_LOAD_B:      return EN_LDB;
      S_SHIFT:       return EN_SHL;
      default:       return EN_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/addr_load_seq.sv
// Drives the enable code of the address register so it ends up holding either
// a direct Na address or an address assembled MSB-first from operand bytes.
module addr_load_seq
  import addr_load_seq_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int BYTE_W = 8,
  parameter int NBYTES = (ADDR_W + BYTE_W - 1) / BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] na_in,
  input  logic              abort,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [1:0]        enables,
  output logic [ADDR_W-1:0] na_out,
  output logic [BYTE_W-1:0] ins_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(NBYTES + 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_na;
  logic [BYTE_W-1:0] r_byte;
  logic              r_err;
  logic              w_start_acc;
  logic              w_accept;

  // abort overrides both a new start and a byte handshake
  assign w_start_acc = (r_state == S_IDLE) && start && !abort;
  assign w_accept    = (r_state == S_WAIT_B) && byte_valid && !abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          case (mode)
            MODE_DIRECT: w_next = S_LDNA;
            MODE_LONG,
            MODE_SHORT:  w_next = S_CLR;
            default:     w_next = S_DONE;
          endcase
        end
      end
      S_LDNA:   w_next = S_DONE;
      S_CLR:    w_next = S_WAIT_B;
      S_WAIT_B: if (w_accept) w_next = S_LOAD_B;
      S_LOAD_B: w_next = (r_cnt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT:  w_next = S_WAIT_B;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_na    <= '0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_na  <= na_in;
        r_err <= (mode == MODE_RSV);
        case (mode)
          MODE_LONG:  r_cnt <= CNT_W'(NBYTES);
          MODE_SHORT: r_cnt <= CNT_W'(2);
          default:    r_cnt <= '0;
        endcase
      end
      if (w_accept) begin
        r_byte <= byte_in;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Outputs depend on the state register only, so each code is held a full cycle.
  assign enables    = en_decode(r_state);
  assign byte_ready = (r_state == S_WAIT_B);
  assign na_out     = (r_state == S_LDNA) ? r_na : '0;
  assign ins_out    = (r_state == S_LOAD_B) ? r_byte : '0;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign err        = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_addr_load_seq.sv
// Scoreboard bench: stimulus queues expected per-cycle codes and final
// addresses; a monitor with a negedge address-register model checks them.
module tb_addr_load_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [17:0] na_in;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [1:0]  enables;
  logic [17:0] na_out;
  logic [7:0]  ins_out;
  logic        busy;
  logic        done;
  logic        err;

  addr_load_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .na_in(na_in),
    .abort(abort), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .enables(enables), .na_out(na_out),
    .ins_out(ins_out), .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [1:0] en;
    logic       rdy;
    logic       dn;
    logic       er;
  } bexp_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] lat;
  } dexp_t;

  bexp_t      eq[$];
  dexp_t      dq[$];
  logic [7:0] bq[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        mon_en = 1'b0;
  logic        feed_en = 1'b0;
  logic [17:0] areg = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Address register model: samples the enable code on negedge.
  always @(negedge clk) begin
    case (enables)
      2'b01: areg <= na_out;
      2'b10: areg <= {areg[17:8], ins_out};
      2'b11: areg <= {areg[9:0], 8'h00};
      default: areg <= areg;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Byte source: presents queued bytes while feed_en, pops on a handshake.
  initial begin
    logic hs;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    forever begin
      @(negedge clk);
      hs = byte_valid && byte_ready && !abort;
      @(posedge clk);
      #2;
      if (hs && bq.size() > 0) void'(bq.pop_front());
      byte_valid = feed_en && (bq.size() > 0);
      byte_in    = (bq.size() > 0) ? bq[0] : 8'h00;
    end
  end

  // Monitor
  initial begin
    bexp_t e;
    dexp_t d;
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        if (busy) begin
          if (eq.size() == 0) begin
            chk("unexpected_busy", 32'(busy), 32'd0);
          end else begin
            e = eq.pop_front();
            chk("enables", 32'(enables), 32'(e.en));
            chk("byte_ready", 32'(byte_ready), 32'(e.rdy));
            chk("done", 32'(done), 32'(e.dn));
            chk("err", 32'(err), 32'(e.er));
          end
        end else begin
          chk("idle_outputs", {enables, byte_ready, done, err, ins_out, na_out}, 32'd0);
        end
        if (done) begin
          if (dq.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            d = dq.pop_front();
            chk("addr_reg", 32'(areg), 32'(d.addr));
            chk("latency", 32'(cyc - start_cyc), d.lat);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pb(input logic [1:0] en, input logic rdy, input logic dn, input logic er);
    bexp_t e;
    e.en = en; e.rdy = rdy; e.dn = dn; e.er = er;
    eq.push_back(e);
  endtask

  task automatic pd(input logic [17:0] addr, input int lat);
    dexp_t d;
    d.addr = addr; d.lat = 32'(lat);
    dq.push_back(d);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [17:0] na);
    start     = 1'b1;
    mode      = m;
    na_in     = na;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 64 && (eq.size() > 0 || dq.size() > 0); i++) step();
    chk(nm, 32'(eq.size() + dq.size()), 32'd0);
    step();
    step();
  endtask

  task automatic push_long_seq();
    pb(2'b01, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      pb(2'b00, 1, 0, 0);
      pb(2'b10, 0, 0, 0);
      if (i < 2) pb(2'b11, 0, 0, 0);
    end
    pb(2'b00, 0, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    na_in = '0;
    abort = 1'b0;
    step();
    mon_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // 1 direct load
    pb(2'b01, 0, 0, 0);
    pb(2'b00, 0, 1, 0);
    pd(18'h2ABCD, 2);
    do_start(2'b00, 18'h2ABCD);
    drain("drain_direct");

    // 2 long immediate, bytes back-to-back
    bq = '{8'h03, 8'h12, 8'h34};
    feed_en = 1'b1;
    push_long_seq();
    pd(18'h31234, 10);
    do_start(2'b01, 18'h00000);
    drain("drain_long");
    feed_en = 1'b0;

    // 3 short immediate with five stalled WAIT_B cycles
    bq = '{8'hAB, 8'hCD};
    pb(2'b01, 0, 0, 0);
    for (int i = 0; i < 6; i++) pb(2'b00, 1, 0, 0);
    pb(2'b10, 0, 0, 0);
    pb(2'b11, 0, 0, 0);
    pb(2'b00, 1, 0, 0);
    pb(2'b10, 0, 0, 0);
    pb(2'b00, 0, 1, 0);
    pd(18'h0ABCD, 12);
    do_start(2'b10, 18'h00000);
    repeat (6) step();
    feed_en = 1'b1;
    drain("drain_backpressure");
    feed_en = 1'b0;

    // 4 abort in the second WAIT_B while a byte is offered
    bq = '{8'h01, 8'h02, 8'h03};
    feed_en = 1'b1;
    pb(2'b01, 0, 0, 0);
    pb(2'b00, 1, 0, 0);
    pb(2'b10, 0, 0, 0);
    pb(2'b11, 0, 0, 0);
    pb(2'b00, 1, 0, 0);
    do_start(2'b01, 18'h00000);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_byte_kept", 32'(bq.size()), 32'd2);
    feed_en = 1'b0;
    bq.delete();
    drain("drain_abort");

    // 5 reserved mode, register keeps the partial value
    pb(2'b00, 0, 1, 1);
    pd(18'h00100, 1);
    do_start(2'b11, 18'h3FFFF);
    drain("drain_reserved");

    // 5b start pulsed while busy is ignored
    pb(2'b01, 0, 0, 0);
    pb(2'b00, 0, 1, 0);
    pd(18'h15A5A, 2);
    do_start(2'b00, 18'h15A5A);
    start = 1'b1;
    mode  = 2'b11;
    na_in = 18'h3FFFF;
    step();
    start = 1'b0;
    drain("drain_ignore_start");

    // 6 synchronous reset during LOAD_B
    bq = '{8'h55, 8'h66};
    feed_en = 1'b1;
    pb(2'b01, 0, 0, 0);
    pb(2'b00, 1, 0, 0);
    pb(2'b10, 0, 0, 0);
    do_start(2'b10, 18'h00000);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    feed_en = 1'b0;
    bq.delete();
    drain("drain_reset");

    // 7 long immediate after reset; high bits of first byte shift out
    bq = '{8'hFF, 8'h12, 8'h34};
    feed_en = 1'b1;
    push_long_seq();
    pd(18'h31234, 10);
    do_start(2'b01, 18'h00000);
    drain("drain_long_overflow");
    feed_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
